// File: rtl/ddr3_odt_pkg.sv
// Shared types and constants for the DDR3 ODT transmit generator and its
// delay-line step sequencer.
package ddr3_odt_pkg;

  localparam int SLOTS      = 4;  // DRAM clocks per FAB_CLK (1:4 gearing)
  localparam int ODT_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MOVE,
    GAP,
    DONE
  } dl_state_t;

  // Latencies beyond what the schedule register can hold saturate at max_lat.
  function automatic logic [4:0] clamp_lat(input logic [4:0] lat, input int max_lat);
    return (int'(lat) > max_lat) ? 5'(max_lat) : lat;
  endfunction

endpackage

// File: rtl/ddr3_odt_tx_gen_if.sv
// Command/status bundle between the PHY scheduler (master) and the ODT
// transmit generator (slave). DDR3_ODT_FORCE_EN adds the ODT_FORCE input.
interface ddr3_odt_tx_gen_if #(parameter int STEP_W = 8);
  import ddr3_odt_pkg::*;

`ifdef DDR3_ODT_FORCE_EN
  logic                  ODT_FORCE;
`endif
  logic                  WR_CMD_VALID;
  logic [1:0]            WR_CMD_SLOT;
  logic [4:0]            ODT_LAT;
  logic                  CFG_ODT_EN;
  logic                  DL_REQ;
  logic                  DL_DIR;
  logic [STEP_W-1:0]     DL_STEPS;
  logic                  DL_OUT_OF_RANGE;
  logic [ODT_DATA_W-1:0] TX_DATA_0;
  logic [ODT_DATA_W-1:0] OE_DATA_0;
  logic                  ODT_EN_0;
  logic                  DL_LOAD_0;
  logic                  DL_MOVE_0;
  logic                  DL_DIRECTION_0;
  logic                  ODT_IDLE;
  logic                  DL_BUSY;
  logic                  DL_DONE;
  logic                  DL_ERR;

  modport master (
`ifdef DDR3_ODT_FORCE_EN
    output ODT_FORCE,
`endif
    output WR_CMD_VALID, WR_CMD_SLOT, ODT_LAT, CFG_ODT_EN,
    output DL_REQ, DL_DIR, DL_STEPS, DL_OUT_OF_RANGE,
    input  TX_DATA_0, OE_DATA_0, ODT_EN_0,
    input  DL_LOAD_0, DL_MOVE_0, DL_DIRECTION_0,
    input  ODT_IDLE, DL_BUSY, DL_DONE, DL_ERR
  );

  modport slave (
`ifdef DDR3_ODT_FORCE_EN
    input  ODT_FORCE,
`endif
    input  WR_CMD_VALID, WR_CMD_SLOT, ODT_LAT, CFG_ODT_EN,
    input  DL_REQ, DL_DIR, DL_STEPS, DL_OUT_OF_RANGE,
    output TX_DATA_0, OE_DATA_0, ODT_EN_0,
    output DL_LOAD_0, DL_MOVE_0, DL_DIRECTION_0,
    output ODT_IDLE, DL_BUSY, DL_DONE, DL_ERR
  );

endinterface

// File: rtl/ddr3_dl_step_seq.sv
// IOD delay-line sequencer: one LOAD pulse, then DL_STEPS MOVE pulses spaced
// by an idle GAP cycle; aborts with an error pulse when the line runs out of range.
module ddr3_dl_step_seq
  import ddr3_odt_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dl_req,
  input  logic              dl_dir,
  input  logic [STEP_W-1:0] dl_steps,
  input  logic              dl_out_of_range,
  output logic              dl_load,
  output logic              dl_move,
  output logic              dl_direction,
  output logic              dl_busy,
  output logic              dl_done,
  output logic              dl_err
);

  dl_state_t         state;
  logic [STEP_W-1:0] moves_left;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      moves_left   <= '0;
      dl_load      <= 1'b0;
      dl_move      <= 1'b0;
      dl_direction <= 1'b0;
      dl_busy      <= 1'b0;
      dl_done      <= 1'b0;
      dl_err       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so every state branch only states
      // what it raises; the later non-blocking assignment in a branch wins.
      dl_load <= 1'b0;
      dl_move <= 1'b0;
      dl_done <= 1'b0;
      dl_err  <= 1'b0;
      case (state)
        // DONE is not busy, so a request landing on it starts the next sequence.
        IDLE, DONE: begin
          state   <= IDLE;
          dl_busy <= 1'b0;
          if (dl_req) begin
            state        <= LOAD;
            dl_load      <= 1'b1;
            dl_busy      <= 1'b1;
            moves_left   <= dl_steps;
            dl_direction <= dl_dir;
          end
        end
        LOAD: begin
          if (moves_left == '0) begin
            state   <= DONE;
            dl_done <= 1'b1;
            dl_busy <= 1'b0;
          end else begin
            state      <= MOVE;
            dl_move    <= 1'b1;
            moves_left <= moves_left - STEP_W'(1);
          end
        end
        MOVE: begin
          if (dl_out_of_range) begin
            state   <= IDLE;
            dl_err  <= 1'b1;
            dl_busy <= 1'b0;
          end else if (moves_left == '0) begin
            state   <= DONE;
            dl_done <= 1'b1;
            dl_busy <= 1'b0;
          end else begin
            state <= GAP;
          end
        end
        GAP: begin
          if (dl_out_of_range) begin
            state   <= IDLE;
            dl_err  <= 1'b1;
            dl_busy <= 1'b0;
          end else begin
            state      <= MOVE;
            dl_move    <= 1'b1;
            moves_left <= moves_left - STEP_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          dl_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ddr3_odt_tx_gen.sv
// DDR3 ODT pin control: turns write commands into the 1:4 geared ODT bitstream
// and drives the IOD enables and delay line. DDR3_ODT_FORCE_EN adds ODT_FORCE.
module ddr3_odt_tx_gen
  import ddr3_odt_pkg::*;
#(
  parameter int MAX_LAT = 15,
  parameter int ODT_LEN = 6,
  parameter int STEP_W  = 8
) (
  input  logic              FAB_CLK,
  input  logic              RESET_N,
  ddr3_odt_tx_gen_if.slave  bus
);

  // Room for the latest possible window: slot 3 plus MAX_LAT plus ODT_LEN bits.
  localparam int SCH_W = MAX_LAT + 3 + ODT_LEN;

  logic [SCH_W-1:0]      sch;
  logic [SCH_W-1:0]      win;
  logic [4:0]            lat;
  logic [5:0]            shamt;
  logic [ODT_DATA_W-1:0] oe_q;
  logic                  odt_en_q;

  always_comb begin
    lat   = clamp_lat(bus.ODT_LAT, MAX_LAT);
    shamt = {1'b0, lat} + {4'b0, bus.WR_CMD_SLOT};
    win   = '0;
    if (bus.WR_CMD_VALID)
      win = {{(SCH_W-ODT_LEN){1'b0}}, {ODT_LEN{1'b1}}} << shamt;
  end

  // Each FAB_CLK retires the four oldest DRAM clocks; new windows OR in so
  // overlapping writes merge into one continuous termination window.
  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      sch      <= '0;
      oe_q     <= '0;
      odt_en_q <= 1'b0;
    end else begin
      sch      <= (sch >> SLOTS) | win;
      oe_q     <= '1;
      odt_en_q <= bus.CFG_ODT_EN;
    end
  end

`ifdef DDR3_ODT_FORCE_EN
  assign bus.TX_DATA_0 = bus.ODT_FORCE ? '1 : sch[ODT_DATA_W-1:0];
`else
  assign bus.TX_DATA_0 = sch[ODT_DATA_W-1:0];
`endif
  assign bus.OE_DATA_0 = oe_q;
  assign bus.ODT_EN_0  = odt_en_q;
  assign bus.ODT_IDLE  = (sch == '0);

  ddr3_dl_step_seq #(.STEP_W(STEP_W)) u_dl_seq (
    .clk             (FAB_CLK),
    .rst_n           (RESET_N),
    .dl_req          (bus.DL_REQ),
    .dl_dir          (bus.DL_DIR),
    .dl_steps        (bus.DL_STEPS),
    .dl_out_of_range (bus.DL_OUT_OF_RANGE),
    .dl_load         (bus.DL_LOAD_0),
    .dl_move         (bus.DL_MOVE_0),
    .dl_direction    (bus.DL_DIRECTION_0),
    .dl_busy         (bus.DL_BUSY),
    .dl_done         (bus.DL_DONE),
    .dl_err          (bus.DL_ERR)
  );

endmodule

// File: tb/tb_ddr3_odt_tx_gen.sv
// Scoreboard bench for ddr3_odt_tx_gen: a DRAM-clock timeline and sequence
// arithmetic predict each FAB_CLK cycle; a monitor compares at the falling edge.
module tb_ddr3_odt_tx_gen;
  import ddr3_odt_pkg::*;

  localparam int MAX_LAT = 15;
  localparam int ODT_LEN = 6;
  localparam int STEP_W  = 8;
  localparam int TL_N    = 16384;

  logic FAB_CLK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  ddr3_odt_tx_gen_if #(.STEP_W(STEP_W)) bus();

  ddr3_odt_tx_gen #(.MAX_LAT(MAX_LAT), .ODT_LEN(ODT_LEN), .STEP_W(STEP_W)) dut (
    .FAB_CLK (FAB_CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] tx;
    logic [3:0] oe;
    logic       odt_en, idle, load, move, dir, busy, done, err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state: absolute DRAM-clock timeline plus the active DL sequence.
  bit   tl[TL_N];
  int   max_set   = -1;
  int   edge_n    = 0;
  bit   seq_act   = 0;
  int   seq_start = 0;
  int   seq_n     = 0;
  int   err_cyc   = -1;
  logic m_dir     = 1'b0;
  logic [3:0] m_oe = 4'h0;
  logic m_odt     = 1'b0;
  bit   last_idle = 1'b1;

  task automatic check(input string name, input int cyc, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int done_rel();
    return (seq_n == 0) ? 1 : 2 * seq_n;
  endfunction

  function automatic bit busy_at(input int c);
    return seq_act && (c - seq_start) >= 0 && (c - seq_start) < done_rel();
  endfunction

  // Cycles from the first MOVE to the last MOVE, gaps included.
  function automatic bit move_phase_at(input int c);
    return seq_act && seq_n > 0 && (c - seq_start) >= 1 && (c - seq_start) <= 2 * seq_n - 1;
  endfunction

  task automatic model_edge();
    int   m;
    int   c;
    int   rel;
    int   lat;
    int   idx;
    exp_t e;
    m = edge_n;
    if (!RESET_N) begin
      for (int i = 4 * (m + 1); i <= max_set; i++) tl[i] = 1'b0;
      max_set = -1;
      seq_act = 0;
      err_cyc = -1;
      m_dir   = 1'b0;
      m_oe    = 4'h0;
      m_odt   = 1'b0;
    end else begin
      if (move_phase_at(m) && bus.DL_OUT_OF_RANGE) begin
        seq_act = 0;
        err_cyc = m + 1;
      end else if (bus.DL_REQ && !busy_at(m)) begin
        seq_act   = 1;
        seq_start = m + 1;
        seq_n     = int'(bus.DL_STEPS);
        m_dir     = bus.DL_DIR;
      end
      if (bus.WR_CMD_VALID) begin
        lat = (int'(bus.ODT_LAT) > MAX_LAT) ? MAX_LAT : int'(bus.ODT_LAT);
        for (int b = 0; b < ODT_LEN; b++) begin
          idx = 4 * (m + 1) + int'(bus.WR_CMD_SLOT) + lat + b;
          if (idx < TL_N) tl[idx] = 1'b1;
          if (idx > max_set) max_set = idx;
        end
      end
      m_oe  = 4'hF;
      m_odt = bus.CFG_ODT_EN;
    end
    c      = m + 1;
    rel    = c - seq_start;
    e.cyc  = c;
    for (int i = 0; i < 4; i++) e.tx[i] = (4 * c + i < TL_N) ? tl[4 * c + i] : 1'b0;
    e.oe     = m_oe;
    e.odt_en = m_odt;
    e.idle   = (max_set < 4 * c);
    e.load   = seq_act && rel == 0;
    e.move   = move_phase_at(c) && (rel % 2 == 1);
    e.done   = seq_act && rel == done_rel();
    e.busy   = busy_at(c);
    e.err    = (err_cyc == c);
    e.dir    = m_dir;
    last_idle = e.idle;
    exp_q.push_back(e);
    edge_n++;
  endtask

  task automatic tick();
    @(posedge FAB_CLK);
    model_edge();
    #1;
    bus.WR_CMD_VALID    = 1'b0;
    bus.DL_REQ          = 1'b0;
    bus.DL_OUT_OF_RANGE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] lat, input logic [1:0] slot);
    bus.ODT_LAT      = lat;
    bus.WR_CMD_SLOT  = slot;
    bus.WR_CMD_VALID = 1'b1;
  endtask

  task automatic dl(input logic [STEP_W-1:0] steps, input logic dir);
    bus.DL_STEPS = steps;
    bus.DL_DIR   = dir;
    bus.DL_REQ   = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge FAB_CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_data",  e.cyc, {4'h0, bus.TX_DATA_0}, {4'h0, e.tx});
        check("oe_data",  e.cyc, {4'h0, bus.OE_DATA_0}, {4'h0, e.oe});
        check("odt_en",   e.cyc, {7'h0, bus.ODT_EN_0},       {7'h0, e.odt_en});
        check("odt_idle", e.cyc, {7'h0, bus.ODT_IDLE},       {7'h0, e.idle});
        check("dl_load",  e.cyc, {7'h0, bus.DL_LOAD_0},      {7'h0, e.load});
        check("dl_move",  e.cyc, {7'h0, bus.DL_MOVE_0},      {7'h0, e.move});
        check("dl_dir",   e.cyc, {7'h0, bus.DL_DIRECTION_0}, {7'h0, e.dir});
        check("dl_busy",  e.cyc, {7'h0, bus.DL_BUSY},        {7'h0, e.busy});
        check("dl_done",  e.cyc, {7'h0, bus.DL_DONE},        {7'h0, e.done});
        check("dl_err",   e.cyc, {7'h0, bus.DL_ERR},         {7'h0, e.err});
      end
    end
  end

  initial begin : stimulus
`ifdef DDR3_ODT_FORCE_EN
    bus.ODT_FORCE = 1'b0;
`endif
    bus.WR_CMD_VALID    = 1'b0;
    bus.WR_CMD_SLOT     = 2'd0;
    bus.ODT_LAT         = 5'd0;
    bus.CFG_ODT_EN      = 1'b1;
    bus.DL_REQ          = 1'b0;
    bus.DL_DIR          = 1'b0;
    bus.DL_STEPS        = '0;
    bus.DL_OUT_OF_RANGE = 1'b0;

    RESET_N = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    repeat (2) tick();

    // Single window at L=0 slot 0, then L=5 slot 2.
    wr(5'd0, 2'd0); tick(); repeat (4) tick();
    wr(5'd5, 2'd2); tick(); repeat (5) tick();

    // Back-to-back windows merge; latency 20 saturates to MAX_LAT.
    wr(5'd0, 2'd0); tick();
    wr(5'd0, 2'd0); tick(); repeat (4) tick();
    wr(5'd20, 2'd3); tick(); repeat (8) tick();

    // Three moves upward; a second request while busy is dropped.
    dl(8'd3, 1'b1); tick(); tick();
    dl(8'd1, 1'b0); tick(); repeat (8) tick();
    dl(8'd0, 1'b0); tick(); repeat (3) tick();

    // Out of range during the gap after the second move.
    dl(8'd5, 1'b0); tick();
    repeat (4) tick();
    bus.DL_OUT_OF_RANGE = 1'b1; tick(); repeat (6) tick();

    // Reset lands in the middle of a window and a MOVE phase.
    wr(5'd3, 2'd1); dl(8'd8, 1'b1); tick(); repeat (3) tick();
    RESET_N = 1'b0; tick();
    RESET_N = 1'b1; repeat (4) tick();

    for (int n = 0; n < 1500; n++) begin
      RESET_N = ($urandom_range(0, 199) != 0);
      bus.CFG_ODT_EN = ($urandom_range(0, 7) != 0);
      if (last_idle && $urandom_range(0, 3) == 0) bus.ODT_LAT = 5'($urandom_range(0, 31));
      bus.WR_CMD_SLOT     = 2'($urandom_range(0, 3));
      bus.WR_CMD_VALID    = ($urandom_range(0, 9) < 4);
      bus.DL_REQ          = ($urandom_range(0, 19) == 0);
      bus.DL_DIR          = 1'($urandom_range(0, 1));
      bus.DL_STEPS        = STEP_W'($urandom_range(0, 6));
      bus.DL_OUT_OF_RANGE = ($urandom_range(0, 29) == 0);
      tick();
    end
    RESET_N = 1'b1;
    repeat (3) tick();

    repeat (3) @(negedge FAB_CLK);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
